// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with valid/ready 2-entry skid buffer
module pipe_skid_reg #(
    parameter int DATA_W    = 32,
    parameter bit FLUSH_CLR = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hlt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                push, pop;

    assign in_ready  = (state_q != FULL) && !hlt && !flush && !rst;
    assign out_valid = (state_q != EMPTY) && !hlt && !flush;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_CLR) begin
                main_d = '0;
                skid_d = '0;
            end
        end else if (!hlt) begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase

            // Saturating count of cycles where a held payload is refused downstream
            if ((state_q != EMPTY) && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hlt;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [15:0] a_stall;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [3:0]  b_stall;

    int total = 0;
    int bad   = 0;

    // Instance a: default parameters. Instance b: payload kept on flush, 4-bit counter.
    pipe_skid_reg #(.DATA_W(32), .FLUSH_CLR(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .stall_cnt(a_stall)
    );

    pipe_skid_reg #(.DATA_W(32), .FLUSH_CLR(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input logic rdy, input logic vld, input logic [31:0] dat);
        chk({tag, "_a_in_ready"}, 64'(a_in_ready), 64'(rdy));
        chk({tag, "_a_out_valid"}, 64'(a_out_valid), 64'(vld));
        chk({tag, "_a_out_data"}, 64'(a_out_data), 64'(dat));
        chk({tag, "_b_in_ready"}, 64'(b_in_ready), 64'(rdy));
        chk({tag, "_b_out_valid"}, 64'(b_out_valid), 64'(vld));
        chk({tag, "_b_out_data"}, 64'(b_out_data), 64'(dat));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hlt = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        #3;
        chk_both("reset", 1'b0, 1'b0, 32'h0);
        chk("reset_a_stall", 64'(a_stall), 64'd0);
        chk("reset_b_stall", 64'(b_stall), 64'd0);

        tick();
        rst = 1'b0;
        #1;
        chk_both("post_reset", 1'b1, 1'b0, 32'h0);

        // Stream 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            tick();
            in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
            #1;
            if (i == 1) chk_both("stream_first", 1'b1, 1'b0, 32'h0);
            else        chk_both("stream", 1'b1, 1'b1, 32'(i - 1));
        end
        tick();
        in_valid = 1'b0;
        #1;
        chk_both("stream_last", 1'b1, 1'b1, 32'd8);
        tick();
        chk_both("stream_drained", 1'b1, 1'b0, 32'd8);
        chk("stream_stall", 64'(a_stall), 64'd0);

        // Backpressure fill to FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        #1;
        chk_both("bp_push_a", 1'b1, 1'b0, 32'd8);
        tick();
        in_data = 32'hB;
        #1;
        chk_both("bp_push_b", 1'b1, 1'b1, 32'hA);
        tick();
        in_valid = 1'b0;
        #1;
        chk_both("bp_full", 1'b0, 1'b1, 32'hA);
        chk("bp_stall1", 64'(a_stall), 64'd1);
        tick();
        out_ready = 1'b1;
        #1;
        chk_both("bp_pop_a", 1'b0, 1'b1, 32'hA);
        chk("bp_stall2", 64'(a_stall), 64'd2);
        tick();
        chk_both("bp_pop_b", 1'b1, 1'b1, 32'hB);
        tick();
        chk_both("bp_empty", 1'b1, 1'b0, 32'hB);
        chk("bp_stall_a", 64'(a_stall), 64'd2);
        chk("bp_stall_b", 64'(b_stall), 64'd2);

        // Refill to FULL then flush
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk_both("flush_cycle", 1'b0, 1'b0, 32'hA);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_a_out_data", 64'(a_out_data), 64'd0);
        chk("flush_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("flush_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("flush_b_out_data", 64'(b_out_data), 64'hA);
        chk("flush_stall", 64'(a_stall), 64'd3);
        in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk_both("post_flush_push", 1'b1, 1'b1, 32'hC);
        tick();
        chk_both("post_flush_empty", 1'b1, 1'b0, 32'hC);

        // hlt for 3 cycles mid-stream
        in_valid = 1'b1; in_data = 32'h10; out_ready = 1'b1;
        tick();
        in_data = 32'h11;
        #1;
        chk_both("hlt_pre", 1'b1, 1'b1, 32'h10);
        tick();
        for (int i = 0; i < 3; i++) begin
            hlt = 1'b1; out_ready = 1'b0; in_data = 32'h12;
            #1;
            chk_both("hlt_frozen", 1'b0, 1'b0, 32'h11);
            tick();
        end
        hlt = 1'b0; out_ready = 1'b1;
        #1;
        chk_both("hlt_resume", 1'b1, 1'b1, 32'h11);
        chk("hlt_stall", 64'(a_stall), 64'd3);
        tick();
        in_data = 32'h13;
        #1;
        chk_both("hlt_next", 1'b1, 1'b1, 32'h12);
        tick();
        in_valid = 1'b0;
        #1;
        chk_both("hlt_last", 1'b1, 1'b1, 32'h13);
        tick();
        chk_both("hlt_drained", 1'b1, 1'b0, 32'h13);

        // Saturation: one entry held with out_ready=0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_b_stall", 64'(b_stall), 64'd15);
        chk("sat_a_stall", 64'(a_stall), 64'd23);
        tick();
        chk("sat_b_hold", 64'(b_stall), 64'd15);
        chk("sat_a_more", 64'(a_stall), 64'd24);

        // Async reset while FULL, asserted between edges
        in_valid = 1'b1; in_data = 32'h6;
        tick();
        in_valid = 1'b0;
        #1;
        chk_both("pre_rst_full", 1'b0, 1'b1, 32'h5);
        #1;
        rst = 1'b1;
        #1;
        chk_both("async_rst", 1'b0, 1'b0, 32'h0);
        chk("async_rst_a_stall", 64'(a_stall), 64'd0);
        chk("async_rst_b_stall", 64'(b_stall), 64'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk_both("rst_release", 1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register that replaces the fixed per-stage register banks between pipeline stages.
- Carries an arbitrary-width payload (control and data fields concatenated by the instantiating stage).
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream and downstream can stall independently at full throughput.
- Keeps the existing hlt (freeze) and flush (bubble insert) controls, and adds a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32: payload width in bits (>=1).
- FLUSH_CLR, 1: 1 = flush zeroes the stored payloads; 0 = flush only clears the valid state and leaves payloads unchanged.
- CNT_W, 16: width of the stall-cycle counter (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries.
- hlt  in  1  synchronous global freeze; no handshake completes while high.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept a payload this cycle.
- out_valid  out  1  out_data holds a valid payload.
- out_data  out  DATA_W  payload presented downstream; always driven from the main register.
- out_ready  in  1  downstream accepts a payload.
- stall_cnt  out  CNT_W  count of cycles with a valid output blocked by downstream.

Behaviour:
- Storage: main register (drives out_data) and skid register, plus a 2-bit occupancy state: EMPTY=0, ONE=1, FULL=2.
- Reset (rst=1, asynchronous): state=EMPTY, main=0, skid=0, stall_cnt=0.
  - Outputs during reset: out_valid=0, out_data=0, in_ready=0.
  - After release, in_ready=1 in the first cycle (when hlt=0 and flush=0).
- Combinational outputs:
  - in_ready = (state != FULL) & !hlt & !flush & !rst.
  - out_valid = (state != EMPTY) & !hlt & !flush.
- Transfer qualifiers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- State transitions and data movement (rising edge, no flush, no hlt):
  - EMPTY: push -> ONE, main<=in_data.
  - ONE: push&pop -> ONE, main<=in_data. push&!pop -> FULL, skid<=in_data. !push&pop -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, main<=skid. No pop -> hold. Push cannot occur because in_ready=0.
- Latency and throughput:
  - Latency in->out is 1 cycle when EMPTY.
  - Sustained throughput is 1 payload/cycle with out_ready held at 1.
  - Order is strictly FIFO; no payload is dropped or duplicated.
- hlt=1:
  - State, main, skid and stall_cnt are frozen.
  - in_ready=0 and out_valid=0, so neither side completes a transfer.
  - out_data still shows the main register.
- flush=1:
  - Overrides hlt; next state = EMPTY.
  - If FLUSH_CLR=1, main<=0 and skid<=0; otherwise payloads are kept.
  - in_in_ready=0 and out_valid=0 during the flush cycle, so nothing is accepted or delivered.
  - stall_cnt is not affected.
- Priority: rst > flush > hlt > handshake.
- stall_cnt:
  - Increments by 1 each cycle with state!=EMPTY & !out_ready & !hlt & !flush.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by rst.
- Reset asserted mid-transfer: all state cleared immediately. The push/pop pending in that cycle is lost, and both sides must re-present.
- in_data is sampled only on push; its value is don't-care otherwise.

Test Plan:
- Stream: rst pulse, then in_valid=1 with in_data=1..8 and out_ready=1.
  - First out_valid one cycle after first push; out_data=1..8 on consecutive cycles; in_ready stays 1; stall_cnt=0.
- Backpressure fill: out_ready=0, push 0xA then 0xB.
  - State FULL; in_ready=0 from the cycle after the second push; out_data=0xA.
  - out_ready=1 -> 0xA, then 0xB, on consecutive cycles; in_ready returns to 1 after the first pop.
  - stall_cnt equals the number of blocked cycles.
- Flush while FULL (FLUSH_CLR=1): pulse flush for 1 cycle.
  - Next cycle out_valid=0, out_data=0, in_ready=1; later pushes start from EMPTY.
  - Repeat with FLUSH_CLR=0: out_data stays 0xA while out_valid=0.
- hlt during streaming: assert hlt for 3 cycles mid-stream.
  - in_ready=0, out_valid=0, state and data frozen.
  - On release the stream resumes with no lost or duplicated payload; stall_cnt does not increment while halted.
- Saturation (CNT_W=4): out_ready=0 with one entry held for 20 cycles.
  - stall_cnt reaches 15 and stays at 15; a rst pulse returns it to 0.
- Async reset with state FULL, asserted between clock edges.
  - out_valid=0, out_data=0, in_ready=0 immediately, without waiting for a clock edge.
  - After release: EMPTY, in_ready=1.
